// File: rtl/pipeline_command_decoder.sv
// pipeline_command_decoder
//
// Byte-serial command decoder that sits between the SPI byte receiver and
// N_PIPELINES block pipelines of the DSP engine.
//
// A command byte carries the opcode in [7:4] and the target pipeline index
// in [3:0]. The operand bytes follow, MSB first, in the fixed order
// block, reg, data, instr, delay. Each opcode skips the fields it does not use.
// Once the last operand byte has been taken, a single one-cycle strobe is
// issued to the target pipeline. The decoder also sequences a swap of the
// active pipeline to any other pipeline.
//
// Optional feature macro: CTRL_TIMEOUT_EN
//   When it is defined, each operand state gives up after TIMEOUT_CYCLES
//   cycles with no byte taken. The decoder then pulses invalid_o and returns
//   to READY. When it is undefined, the operand states wait forever and no
//   counter is built.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   in_byte_i, in_ready_i          received byte and its valid flag
//   next_o                         one-cycle pulse: byte consumed
//   block_target_o                 latched block number
//   reg_target_o                   latched register number
//   data_out_o                     latched payload
//   instr_out_o                    latched instruction
//   buf_init_delay_o               latched delay-buffer length
//   block_instr_write_o            one-hot strobe, per pipeline
//   block_reg_write_o              one-hot strobe (WRITE_REG / UPDATE_REG)
//   reg_writes_commit_o            one-hot strobe, per pipeline
//   alloc_delay_o                  one-hot strobe, per pipeline
//   pipeline_reset_o               one-hot strobe, per pipeline
//   pipeline_enables_o             level, per-pipeline enable
//   pipeline_regfiles_syncing_i    regfile busy, per pipeline
//   pipeline_resetting_i           reset in progress, per pipeline
//   swap_pipelines_o               pulse: request a swap
//   pipelines_swapping_i           swap in progress
//   current_pipeline_o             index of the active pipeline
//   set_input_gain_o               gain strobe
//   set_output_gain_o              gain strobe
//   invalid_o                      pulse: bad opcode, bad index or timeout
//   control_state_o                current FSM state code

module pipeline_command_decoder #(
  parameter int N_PIPELINES    = 2,
  parameter int N_BLOCKS       = 256,
  parameter int DATA_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DELAY_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int BN_BITS       = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1,
  localparam int CP_W          = (N_PIPELINES > 1) ? $clog2(N_PIPELINES) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [7:0]                in_byte_i,
  input  logic                      in_ready_i,
  output logic                      next_o,
  output logic [BN_BITS-1:0]        block_target_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_target_o,
  output logic [DATA_WIDTH-1:0]     data_out_o,
  output logic [INSTR_WIDTH-1:0]    instr_out_o,
  output logic [DELAY_WIDTH-1:0]    buf_init_delay_o,
  output logic [N_PIPELINES-1:0]    block_instr_write_o,
  output logic [N_PIPELINES-1:0]    block_reg_write_o,
  output logic [N_PIPELINES-1:0]    reg_writes_commit_o,
  output logic [N_PIPELINES-1:0]    alloc_delay_o,
  output logic [N_PIPELINES-1:0]    pipeline_reset_o,
  output logic [N_PIPELINES-1:0]    pipeline_enables_o,
  input  logic [N_PIPELINES-1:0]    pipeline_regfiles_syncing_i,
  input  logic [N_PIPELINES-1:0]    pipeline_resetting_i,
  output logic                      swap_pipelines_o,
  input  logic                      pipelines_swapping_i,
  output logic [CP_W-1:0]           current_pipeline_o,
  output logic                      set_input_gain_o,
  output logic                      set_output_gain_o,
  output logic                      invalid_o,
  output logic [7:0]                control_state_o
);

  localparam int BN_BYTES = (BN_BITS + 7) / 8;

  localparam logic [3:0] OP_WRITE_INSTR = 4'd1;
  localparam logic [3:0] OP_WRITE_REG   = 4'd2;
  localparam logic [3:0] OP_UPDATE_REG  = 4'd3;
  localparam logic [3:0] OP_COMMIT      = 4'd4;
  localparam logic [3:0] OP_ALLOC_DELAY = 4'd5;
  localparam logic [3:0] OP_SWAP        = 4'd6;
  localparam logic [3:0] OP_RESET       = 4'd7;
  localparam logic [3:0] OP_IN_GAIN     = 4'd8;
  localparam logic [3:0] OP_OUT_GAIN    = 4'd9;

  // The operand states are numbered in their arrival order. next_field
  // depends on this ordering.
  typedef enum logic [7:0] {
    S_READY      = 8'd0,
    S_DECODE     = 8'd1,
    S_BLOCK      = 8'd2,
    S_REG        = 8'd3,
    S_DATA       = 8'd4,
    S_INSTR      = 8'd5,
    S_DELAY      = 8'd6,
    S_EXEC       = 8'd7,
    S_SWAP_WAIT  = 8'd8,
    S_RESET_WAIT = 8'd9
  } state_e;

  state_e                    state_q, state_d;
  logic                      guard_q;
  logic [7:0]                byte_cnt_q, byte_cnt_d;
  logic                      phase_q, phase_d;
  logic [CP_W-1:0]           current_q, current_d;
  logic [N_PIPELINES-1:0]    enables_q, enables_d;

  logic [3:0]                op_q;
  logic [3:0]                idx_q;
  logic [BN_BITS-1:0]        block_q;
  logic [REG_ADDR_WIDTH-1:0] reg_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [INSTR_WIDTH-1:0]    instr_q;
  logic [DELAY_WIDTH-1:0]    delay_q;

  logic                      in_operand;
  logic                      want_byte;
  logic                      take;
  logic                      last_byte;
  logic                      cmd_valid;
  logic                      reg_stall;
  logic                      timeout_hit;
  logic [N_PIPELINES-1:0]    idx_onehot;
  logic [N_PIPELINES-1:0]    cur_onehot;

  // Returns the first field after `cur` that opcode `op` uses, or EXEC when
  // no field is left.
  function automatic state_e next_field(input logic [3:0] op, input state_e cur);
    logic use_block, use_reg, use_data, use_instr, use_delay;
    state_e nf;
    use_block = (op == OP_WRITE_INSTR) || (op == OP_WRITE_REG) || (op == OP_UPDATE_REG);
    use_reg   = (op == OP_WRITE_REG) || (op == OP_UPDATE_REG);
    use_data  = (op == OP_WRITE_REG) || (op == OP_UPDATE_REG) || (op == OP_ALLOC_DELAY) ||
                (op == OP_IN_GAIN) || (op == OP_OUT_GAIN);
    use_instr = (op == OP_WRITE_INSTR);
    use_delay = (op == OP_ALLOC_DELAY);
    nf = S_EXEC;
    if ((cur < S_DELAY) && use_delay) nf = S_DELAY;
    if ((cur < S_INSTR) && use_instr) nf = S_INSTR;
    if ((cur < S_DATA)  && use_data)  nf = S_DATA;
    if ((cur < S_REG)   && use_reg)   nf = S_REG;
    if ((cur < S_BLOCK) && use_block) nf = S_BLOCK;
    return nf;
  endfunction

  function automatic logic [7:0] field_bytes(input state_e s);
    logic [7:0] n;
    case (s)
      S_BLOCK: n = 8'(BN_BYTES);
      S_DATA:  n = 8'(DATA_WIDTH / 8);
      S_INSTR: n = 8'(INSTR_WIDTH / 8);
      S_DELAY: n = 8'(DELAY_WIDTH / 8);
      default: n = 8'd1;
    endcase
    return n;
  endfunction

  assign in_operand = (state_q == S_BLOCK) || (state_q == S_REG) || (state_q == S_DATA) ||
                      (state_q == S_INSTR) || (state_q == S_DELAY);
  assign want_byte  = (state_q == S_READY) || in_operand;
  // guard_q blocks a byte in the cycle after next_o. Bytes are also ignored
  // during reset, so the operand latches really hold through reset.
  assign take       = want_byte && in_ready_i && !guard_q && !reset_i;
  assign last_byte  = (byte_cnt_q == (field_bytes(state_q) - 8'd1));
  assign cmd_valid  = (op_q >= OP_WRITE_INSTR) && (op_q <= OP_OUT_GAIN) &&
                      ({28'd0, idx_q} < 32'(N_PIPELINES));
  assign idx_onehot = N_PIPELINES'(1) << idx_q;
  assign cur_onehot = N_PIPELINES'(1) << current_q;
  assign reg_stall  = pipelines_swapping_i || ((pipeline_regfiles_syncing_i & idx_onehot) != '0);

`ifdef CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q;

  // Counts the cycles since the last byte was taken. The counter rests in READY.
  always_ff @(posedge clk_i) begin
    if (reset_i || take || (state_q == S_READY)) begin
      to_cnt_q <= '0;
    end else if (!timeout_hit) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = in_operand && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_READY;
      guard_q    <= 1'b0;
      byte_cnt_q <= '0;
      phase_q    <= 1'b0;
      current_q  <= '0;
      enables_q  <= N_PIPELINES'(1);
    end else begin
      state_q    <= state_d;
      guard_q    <= take;
      byte_cnt_q <= byte_cnt_d;
      phase_q    <= phase_d;
      current_q  <= current_d;
      enables_q  <= enables_d;
    end
  end

  // Command and operand latches. They have no reset, so the last command's
  // values stay visible across a reset.
  always_ff @(posedge clk_i) begin
    if (take) begin
      case (state_q)
        S_READY: begin
          op_q  <= in_byte_i[7:4];
          idx_q <= in_byte_i[3:0];
        end
        S_BLOCK: block_q <= BN_BITS'({block_q, in_byte_i});
        S_REG:   reg_q   <= REG_ADDR_WIDTH'({reg_q, in_byte_i});
        S_DATA:  data_q  <= DATA_WIDTH'({data_q, in_byte_i});
        S_INSTR: instr_q <= INSTR_WIDTH'({instr_q, in_byte_i});
        S_DELAY: delay_q <= DELAY_WIDTH'({delay_q, in_byte_i});
        default: ;
      endcase
    end
  end

  // Next-state logic and strobe outputs.
  // phase_q marks the first cycle of SWAP_WAIT and RESET_WAIT. Those cycles
  // are ignored, so the pipelines have time to raise their busy flags.
  always_comb begin
    state_d             = state_q;
    byte_cnt_d          = byte_cnt_q;
    phase_d             = phase_q;
    current_d           = current_q;
    enables_d           = enables_q;
    block_instr_write_o = '0;
    block_reg_write_o   = '0;
    reg_writes_commit_o = '0;
    alloc_delay_o       = '0;
    pipeline_reset_o    = '0;
    swap_pipelines_o    = 1'b0;
    set_input_gain_o    = 1'b0;
    set_output_gain_o   = 1'b0;
    invalid_o           = 1'b0;

    case (state_q)
      S_READY: begin
        if (take) state_d = S_DECODE;
      end

      S_DECODE: begin
        if (!cmd_valid) begin
          invalid_o = 1'b1;
          state_d   = S_READY;
        end else begin
          case (op_q)
            OP_COMMIT: begin
              reg_writes_commit_o = idx_onehot;
              state_d             = S_READY;
            end
            OP_RESET: begin
              pipeline_reset_o = idx_onehot;
              state_d          = S_READY;
            end
            OP_SWAP: begin
              if (CP_W'(idx_q) == current_q) begin
                state_d = S_READY;
              end else begin
                swap_pipelines_o    = 1'b1;
                reg_writes_commit_o = idx_onehot;
                enables_d           = enables_q | idx_onehot;
                phase_d             = 1'b1;
                state_d             = S_SWAP_WAIT;
              end
            end
            default: begin
              byte_cnt_d = '0;
              state_d    = next_field(op_q, S_DECODE);
            end
          endcase
        end
      end

      S_BLOCK, S_REG, S_DATA, S_INSTR, S_DELAY: begin
        if (take) begin
          if (last_byte) begin
            byte_cnt_d = '0;
            state_d    = next_field(op_q, state_q);
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end else if (timeout_hit) begin
          invalid_o = 1'b1;
          state_d   = S_READY;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_WRITE_INSTR: begin
            block_instr_write_o = idx_onehot;
            state_d             = S_READY;
          end
          OP_WRITE_REG, OP_UPDATE_REG: begin
            if (!reg_stall) begin
              block_reg_write_o = idx_onehot;
              state_d           = S_READY;
            end
          end
          OP_ALLOC_DELAY: begin
            alloc_delay_o = idx_onehot;
            state_d       = S_READY;
          end
          OP_IN_GAIN: begin
            set_input_gain_o = 1'b1;
            state_d          = S_READY;
          end
          OP_OUT_GAIN: begin
            set_output_gain_o = 1'b1;
            state_d           = S_READY;
          end
          default: state_d = S_READY;
        endcase
      end

      S_SWAP_WAIT: begin
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (!pipelines_swapping_i) begin
          current_d = CP_W'(idx_q);
          enables_d = enables_q & ~cur_onehot;
          phase_d   = 1'b1;
          state_d   = S_RESET_WAIT;
        end
      end

      S_RESET_WAIT: begin
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (pipeline_resetting_i == '0) begin
          state_d = S_READY;
        end
      end

      default: state_d = S_READY;
    endcase
  end

  assign next_o             = take;
  assign block_target_o     = block_q;
  assign reg_target_o       = reg_q;
  assign data_out_o         = data_q;
  assign instr_out_o        = instr_q;
  assign buf_init_delay_o   = delay_q;
  assign pipeline_enables_o = enables_q;
  assign current_pipeline_o = current_q;
  assign control_state_o    = state_q;

endmodule

// File: tb/tb_pipeline_command_decoder.sv
// Directed testbench for pipeline_command_decoder (N_PIPELINES=2,
// TIMEOUT_CYCLES=16). The bytes are driven just after a rising edge. The
// outputs are sampled on the falling edge.

module tb_pipeline_command_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready = 1'b0;
  logic        next;
  logic [7:0]  block_target;
  logic [3:0]  reg_target;
  logic [15:0] data_out;
  logic [31:0] instr_out;
  logic [31:0] buf_init_delay;
  logic [1:0]  block_instr_write, block_reg_write, reg_writes_commit;
  logic [1:0]  alloc_delay, pipeline_reset, pipeline_enables;
  logic [1:0]  regfiles_syncing = 2'b00;
  logic [1:0]  pipeline_resetting = 2'b00;
  logic        swap_pipelines;
  logic        pipelines_swapping = 1'b0;
  logic [0:0]  current_pipeline;
  logic        set_input_gain, set_output_gain, invalid;
  logic [7:0]  control_state;

  int errors = 0;
  int checks = 0;
  int cycle = 0;

  // Counters for the strobe monitor.
  int nextCount, lastNextCycle, backToBack;
  int regWrCount, regWrCycle, instrWrCount, commitCount, allocCount, rstCount;
  int swapCount, invalidCount, invalidCycle, inGainCount, outGainCount;
  logic [1:0] regWrVal, instrWrVal, commitVal, allocVal, rstVal;
  logic prevNext = 1'b0;

  pipeline_command_decoder #(
    .N_PIPELINES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .in_byte_i(in_byte),
    .in_ready_i(in_ready),
    .next_o(next),
    .block_target_o(block_target),
    .reg_target_o(reg_target),
    .data_out_o(data_out),
    .instr_out_o(instr_out),
    .buf_init_delay_o(buf_init_delay),
    .block_instr_write_o(block_instr_write),
    .block_reg_write_o(block_reg_write),
    .reg_writes_commit_o(reg_writes_commit),
    .alloc_delay_o(alloc_delay),
    .pipeline_reset_o(pipeline_reset),
    .pipeline_enables_o(pipeline_enables),
    .pipeline_regfiles_syncing_i(regfiles_syncing),
    .pipeline_resetting_i(pipeline_resetting),
    .swap_pipelines_o(swap_pipelines),
    .pipelines_swapping_i(pipelines_swapping),
    .current_pipeline_o(current_pipeline),
    .set_input_gain_o(set_input_gain),
    .set_output_gain_o(set_output_gain),
    .invalid_o(invalid),
    .control_state_o(control_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Records every strobe, and the cycle it occurred in, at the falling edge.
  always @(negedge clk) begin
    if (next) begin
      nextCount++;
      lastNextCycle = cycle;
      if (prevNext) backToBack++;
    end
    prevNext = next;
    if (block_reg_write != 0)   begin regWrCount++; regWrVal = block_reg_write; regWrCycle = cycle; end
    if (block_instr_write != 0) begin instrWrCount++; instrWrVal = block_instr_write; end
    if (reg_writes_commit != 0) begin commitCount++; commitVal = reg_writes_commit; end
    if (alloc_delay != 0)       begin allocCount++; allocVal = alloc_delay; end
    if (pipeline_reset != 0)    begin rstCount++; rstVal = pipeline_reset; end
    if (swap_pipelines)  swapCount++;
    if (invalid)         begin invalidCount++; invalidCycle = cycle; end
    if (set_input_gain)  inGainCount++;
    if (set_output_gain) outGainCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounts();
    nextCount = 0; backToBack = 0; regWrCount = 0; instrWrCount = 0; commitCount = 0;
    allocCount = 0; rstCount = 0; swapCount = 0; invalidCount = 0;
    inGainCount = 0; outGainCount = 0;
    regWrVal = '0; instrWrVal = '0; commitVal = '0; allocVal = '0; rstVal = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one byte and holds it until next is seen. The task returns 1 time
  // unit after the edge that consumed the byte.
  task automatic applyStimulus(input logic [7:0] b);
    int tries;
    tries = 0;
    in_byte  = b;
    in_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (next) break;
      tries++;
      if (tries > 100) begin
        checkOutput("byte_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_ready = 1'b0;
  endtask

  initial begin
    int firstCyc, lastCyc, n, waitCnt;
    clearCounts();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    checkOutput("reset_state", control_state, 8'd0);
    checkOutput("reset_current", current_pipeline, 1'b0);
    checkOutput("reset_enables", pipeline_enables, 2'b01);
    checkOutput("reset_strobes", {block_instr_write, block_reg_write, reg_writes_commit,
                alloc_delay, pipeline_reset, swap_pipelines, invalid, next}, 13'd0);

    // WRITE_REG to pipeline 1
    applyStimulus(8'h21);
    clearCounts();
    applyStimulus(8'h05);
    applyStimulus(8'h03);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    idle(3);
    checkOutput("wreg_count", regWrCount, 1);
    checkOutput("wreg_onehot", regWrVal, 2'b10);
    checkOutput("wreg_block", block_target, 8'h05);
    checkOutput("wreg_reg", reg_target, 4'h3);
    checkOutput("wreg_data", data_out, 16'h1234);
    checkOutput("wreg_next_pulses", nextCount, 4);
    checkOutput("wreg_latency", regWrCycle - lastNextCycle, 1);
    checkOutput("wreg_ready", control_state, 8'd0);

    // WRITE_INSTR to pipeline 0
    clearCounts();
    applyStimulus(8'h10);
    applyStimulus(8'h07);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    idle(3);
    checkOutput("winstr_count", instrWrCount, 1);
    checkOutput("winstr_onehot", instrWrVal, 2'b01);
    checkOutput("winstr_value", instr_out, 32'hDEADBEEF);
    checkOutput("winstr_block", block_target, 8'h07);
    checkOutput("winstr_no_regwrite", regWrCount, 0);

    // Operand bytes streamed with in_ready held high. Because of the guard
    // cycle, a byte can be taken at most every other cycle.
    clearCounts();
    applyStimulus(8'h10);
    in_byte = 8'h11;
    in_ready = 1'b1;
    n = 0; firstCyc = 0; lastCyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (next) begin
        if (n == 0) firstCyc = cycle;
        lastCyc = cycle;
        n++;
      end
      if (n == 5) break;
    end
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    idle(3);
    checkOutput("stream_bytes", n, 5);
    checkOutput("stream_span", lastCyc - firstCyc, 8);
    checkOutput("stream_no_b2b", backToBack, 0);
    checkOutput("stream_instr", instr_out, 32'h11111111);
    checkOutput("stream_strobe", instrWrVal, 2'b01);

    // COMMIT strobes in DECODE, one cycle after the command byte.
    clearCounts();
    applyStimulus(8'h40);
    idle(2);
    checkOutput("commit_count", commitCount, 1);
    checkOutput("commit_onehot", commitVal, 2'b01);

    // RESET pipeline 1
    clearCounts();
    applyStimulus(8'h71);
    idle(2);
    checkOutput("preset_count", rstCount, 1);
    checkOutput("preset_onehot", rstVal, 2'b10);

    // ALLOC_DELAY: data then delay
    clearCounts();
    applyStimulus(8'h50);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    idle(2);
    checkOutput("alloc_onehot", allocVal, 2'b01);
    checkOutput("alloc_data", data_out, 16'h0010);
    checkOutput("alloc_delay", buf_init_delay, 32'h00000100);

    // Gains
    clearCounts();
    applyStimulus(8'h80);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    idle(2);
    checkOutput("ingain_count", inGainCount, 1);
    checkOutput("ingain_data", data_out, 16'h1122);
    clearCounts();
    applyStimulus(8'h91);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    idle(2);
    checkOutput("outgain_count", outGainCount, 1);
    checkOutput("outgain_no_in", inGainCount, 0);

    // Bad opcode, then an out-of-range index.
    clearCounts();
    applyStimulus(8'hF0);
    idle(2);
    checkOutput("badop_invalid", invalidCount, 1);
    checkOutput("badop_ready", control_state, 8'd0);
    clearCounts();
    applyStimulus(8'h13);
    idle(2);
    checkOutput("badidx_invalid", invalidCount, 1);
    checkOutput("badidx_nostrobe", regWrCount + instrWrCount + commitCount + allocCount +
                rstCount + swapCount, 0);
    checkOutput("badidx_ready", control_state, 8'd0);

    // UPDATE_REG stalled by syncing[1]
    clearCounts();
    regfiles_syncing = 2'b10;
    applyStimulus(8'h31);
    applyStimulus(8'h02);
    applyStimulus(8'h04);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    idle(10);
    checkOutput("sync_stalled", regWrCount, 0);
    checkOutput("sync_in_exec", control_state, 8'd7);
    regfiles_syncing = 2'b00;
    idle(2);
    checkOutput("sync_released", regWrCount, 1);
    checkOutput("sync_onehot", regWrVal, 2'b10);
    checkOutput("sync_data", data_out, 16'hABCD);

    // SWAP to pipeline 1 while a swap is in progress
    clearCounts();
    pipelines_swapping = 1'b1;
    applyStimulus(8'h61);
    idle(5);
    checkOutput("swap_current_held", current_pipeline, 1'b0);
    checkOutput("swap_pulse", swapCount, 1);
    pipelines_swapping = 1'b0;
    idle(4);
    checkOutput("swap_current", current_pipeline, 1'b1);
    checkOutput("swap_enables", pipeline_enables, 2'b10);
    checkOutput("swap_commit", commitVal, 2'b10);
    checkOutput("swap_ready", control_state, 8'd0);

    // SWAP to the pipeline that is already active does nothing.
    clearCounts();
    applyStimulus(8'h61);
    idle(3);
    checkOutput("swap_same_nopulse", swapCount + commitCount, 0);
    checkOutput("swap_same_current", current_pipeline, 1'b1);

`ifdef CTRL_TIMEOUT_EN
    // Timeout after silence, then recovery
    clearCounts();
    applyStimulus(8'h20);
    waitCnt = 0;
    while (invalidCount == 0 && waitCnt < 40) begin
      idle(1);
      waitCnt++;
    end
    checkOutput("timeout_seen", invalidCount, 1);
    checkOutput("timeout_delay", invalidCycle - lastNextCycle, 16);
    checkOutput("timeout_nostrobe", regWrCount, 0);
    clearCounts();
    applyStimulus(8'h40);
    idle(2);
    checkOutput("timeout_recover", commitVal, 2'b01);
`endif

    // Reset in the middle of a command: no strobe, operand latches kept.
    clearCounts();
    applyStimulus(8'h21);
    applyStimulus(8'h09);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
    checkOutput("midreset_nostrobe", regWrCount, 0);
    checkOutput("midreset_state", control_state, 8'd0);
    checkOutput("midreset_block_kept", block_target, 8'h09);
    checkOutput("midreset_current", current_pipeline, 1'b0);
    checkOutput("midreset_enables", pipeline_enables, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
